// File: rtl/segway_drive_seq.sv
// Soft-start / power sequencer feeding Segway_Math: ss_tmr ramp, pwr_up gate, steering enable, overspeed fault.
// Optional feature macro SEQ_FAST_RESTART_EN: pwr_req during ramp-down restarts the ramp from the current ss_tmr.
module segway_drive_seq #(
    parameter int RAMP_DIV   = 1024,
    parameter int TF_PERSIST = 4,
    parameter int TF_CLEAR   = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwr_req,
    input  logic       en_steer_req,
    input  logic       too_fast,
    output logic [7:0] ss_tmr,
    output logic       pwr_up,
    output logic       en_steer,
    output logic       ovr_flt,
    output logic [2:0] seq_st
);
    localparam int PW  = $clog2(RAMP_DIV);
    localparam int TFW = $clog2(TF_PERSIST + 1);
    localparam int CLW = $clog2(TF_CLEAR + 1);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RAMP   = 3'd1,
        ST_RUN    = 3'd2,
        ST_OVRSPD = 3'd3,
        ST_RAMPDN = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_ss_tmr, w_ss_nxt;
    logic [PW-1:0]    r_presc, w_presc_nxt;
    logic [TFW-1:0]   r_tf_cnt, w_tf_nxt, w_tf_inc;
    logic [CLW-1:0]   r_clr_cnt, w_clr_nxt, w_clr_inc;
    logic             r_pwr_up, r_en_steer, r_ovr_flt;
    logic             w_tick, w_restart;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    function automatic logic [7:0] sat_dec8(input logic [7:0] v);
        return (v == 8'h00) ? 8'h00 : v - 8'd1;
    endfunction

`ifdef SEQ_FAST_RESTART_EN
    assign w_restart = pwr_req;
`else
    assign w_restart = 1'b0;
`endif

    assign w_tick    = (r_presc == PW'(RAMP_DIV - 1));
    assign w_tf_inc  = r_tf_cnt + TFW'(1);
    assign w_clr_inc = r_clr_cnt + CLW'(1);

    // Prescaler and counters default to 0, so any state change clears them.
    always_comb begin
        w_state_nxt = r_state;
        w_ss_nxt    = r_ss_tmr;
        w_presc_nxt = '0;
        w_tf_nxt    = '0;
        w_clr_nxt   = '0;
        case (r_state)
            ST_OFF: begin
                w_ss_nxt = 8'd0;
                if (pwr_req) w_state_nxt = ST_RAMP;
            end
            ST_RAMP: begin
                if (!pwr_req) begin
                    w_state_nxt = ST_RAMPDN;
                end else if (w_tick) begin
                    w_ss_nxt = sat_inc8(r_ss_tmr);
                    if (r_ss_tmr >= 8'd254) w_state_nxt = ST_RUN;
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            ST_RUN: begin
                w_ss_nxt = 8'hFF;
                if (!pwr_req) begin
                    w_state_nxt = ST_RAMPDN;
                end else if (too_fast) begin
                    if (w_tf_inc == TFW'(TF_PERSIST)) w_state_nxt = ST_OVRSPD;
                    else                               w_tf_nxt    = w_tf_inc;
                end
            end
            ST_OVRSPD: begin
                w_ss_nxt = 8'hFF;
                if (!pwr_req) begin
                    w_state_nxt = ST_RAMPDN;
                end else if (!too_fast) begin
                    if (w_clr_inc == CLW'(TF_CLEAR)) w_state_nxt = ST_RUN;
                    else                              w_clr_nxt   = w_clr_inc;
                end
            end
            ST_RAMPDN: begin
                if (w_restart) begin
                    w_state_nxt = ST_RAMP;
                end else if (r_ss_tmr == 8'd0) begin
                    w_state_nxt = ST_OFF;
                end else if (w_tick) begin
                    w_ss_nxt = sat_dec8(r_ss_tmr);
                    if (r_ss_tmr == 8'd1) w_state_nxt = ST_OFF;
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_ss_nxt    = 8'd0;
            end
        endcase
    end

    // Flag outputs are registered from the next state so they align with seq_st.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_OFF;
            r_ss_tmr   <= 8'd0;
            r_presc    <= '0;
            r_tf_cnt   <= '0;
            r_clr_cnt  <= '0;
            r_pwr_up   <= 1'b0;
            r_en_steer <= 1'b0;
            r_ovr_flt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ss_tmr   <= w_ss_nxt;
            r_presc    <= w_presc_nxt;
            r_tf_cnt   <= w_tf_nxt;
            r_clr_cnt  <= w_clr_nxt;
            r_pwr_up   <= (w_state_nxt != ST_OFF);
            r_en_steer <= (w_state_nxt == ST_RUN) && en_steer_req;
            r_ovr_flt  <= (w_state_nxt == ST_OVRSPD);
        end
    end

    assign ss_tmr   = r_ss_tmr;
    assign pwr_up   = r_pwr_up;
    assign en_steer = r_en_steer;
    assign ovr_flt  = r_ovr_flt;
    assign seq_st   = r_state;
endmodule

// File: tb/tb_segway_drive_seq.sv
// Directed bench for segway_drive_seq with RAMP_DIV=4, TF_PERSIST=3, TF_CLEAR=8.
module tb_segway_drive_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwr_req = 1'b0;
    logic       en_steer_req = 1'b0;
    logic       too_fast = 1'b0;
    logic [7:0] ss_tmr;
    logic       pwr_up, en_steer, ovr_flt;
    logic [2:0] seq_st;

    int n_tests = 0;
    int n_fail  = 0;

    segway_drive_seq #(
        .RAMP_DIV  (4),
        .TF_PERSIST(3),
        .TF_CLEAR  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwr_req     (pwr_req),
        .en_steer_req(en_steer_req),
        .too_fast    (too_fast),
        .ss_tmr      (ss_tmr),
        .pwr_up      (pwr_up),
        .en_steer    (en_steer),
        .ovr_flt     (ovr_flt),
        .seq_st      (seq_st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int ss, input int pu, input int es,
                           input int of, input int st);
        chk({tag, ".ss_tmr"},   32'(ss_tmr),   32'(ss));
        chk({tag, ".pwr_up"},   32'(pwr_up),   32'(pu));
        chk({tag, ".en_steer"}, 32'(en_steer), 32'(es));
        chk({tag, ".ovr_flt"},  32'(ovr_flt),  32'(of));
        chk({tag, ".seq_st"},   32'(seq_st),   32'(st));
    endtask

    initial begin
        // 1: reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            pwr_req      = i[0];
            too_fast     = i[1];
            en_steer_req = ~i[0];
            step(1);
            chk_all("rst_hold", 0, 0, 0, 0, 0);
        end
        pwr_req = 1'b0; too_fast = 1'b0; en_steer_req = 1'b0;
        rst_n = 1'b1;
        step(3);
        chk_all("rst_idle", 0, 0, 0, 0, 0);

        // 2: ramp up
        pwr_req = 1'b1;
        step(1);
        chk_all("ramp_c1", 0, 1, 0, 0, 1);
        step(4);
        chk("ramp_c5.ss", 32'(ss_tmr), 32'd1);
        step(1015);
        chk_all("ramp_c1020", 254, 1, 0, 0, 1);
        step(1);
        chk_all("ramp_c1021", 255, 1, 0, 0, 2);
        en_steer_req = 1'b1;
        step(1);
        chk("run_steer", 32'(en_steer), 32'd1);

        // 3: overspeed supervision
        too_fast = 1'b1;
        step(2);
        chk("tf2.seq", 32'(seq_st), 32'd2);
        too_fast = 1'b0;
        step(1);
        chk_all("tf2_low", 255, 1, 1, 0, 2);
        too_fast = 1'b1;
        step(2);
        chk("tf3_pre.seq", 32'(seq_st), 32'd2);
        step(1);
        chk_all("ovrspd", 255, 1, 0, 1, 3);
        too_fast = 1'b0;
        step(7);
        chk_all("clr7", 255, 1, 0, 1, 3);
        step(1);
        chk_all("clr8", 255, 1, 1, 0, 2);

        // 4a: ramp-down from RUN, beating a tf_cnt that would complete
        too_fast = 1'b1;
        step(2);
        pwr_req = 1'b0;
        step(1);
        chk_all("rdn_entry", 255, 1, 0, 0, 4);
        too_fast = 1'b0;
        step(4);
        chk("rdn_c4.ss", 32'(ss_tmr), 32'd254);
        step(1015);
        chk_all("rdn_c1019", 1, 1, 0, 0, 4);
        step(1);
        chk_all("rdn_c1020", 0, 0, 0, 0, 0);

        // 4b: ramp-down from OVRSPD with too_fast still high
        pwr_req = 1'b1;
        step(1021);
        chk("rerun.seq", 32'(seq_st), 32'd2);
        too_fast = 1'b1;
        step(3);
        chk_all("ovr2", 255, 1, 0, 1, 3);
        pwr_req = 1'b0;
        step(1);
        chk_all("ovr_rdn", 255, 1, 0, 0, 4);
        too_fast = 1'b0;
        step(820);
        chk_all("rdn50", 50, 1, 0, 0, 4);

        // 6: pwr_req returns during ramp-down
        pwr_req = 1'b1;
`ifdef SEQ_FAST_RESTART_EN
        step(1);
        chk_all("fr_ramp", 50, 1, 0, 0, 1);
        step(4);
        chk("fr_ss51", 32'(ss_tmr), 32'd51);
        step(196);
`else
        step(1);
        chk_all("nofr_hold", 50, 1, 0, 0, 4);
        step(198);
        chk("nofr_ss1", 32'(ss_tmr), 32'd1);
        step(1);
        chk_all("nofr_off", 0, 0, 0, 0, 0);
        step(1);
        chk_all("nofr_ramp", 0, 1, 0, 0, 1);
        step(400);
`endif
        chk_all("ramp100", 100, 1, 0, 0, 1);

        // 5: asynchronous reset mid-ramp
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        pwr_req = 1'b0;
        rst_n   = 1'b1;
        step(2);
        chk_all("post_rst", 0, 0, 0, 0, 0);

        // ramp-down entered with ss_tmr==0 reaches OFF next cycle
        pwr_req = 1'b1;
        step(1);
        pwr_req = 1'b0;
        step(1);
        chk_all("rdn0_entry", 0, 1, 0, 0, 4);
        step(1);
        chk_all("rdn0_off", 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
